// File: rtl/mul32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul32_seq_ctrl
// Purpose  : Unsigned 32x32 shift-and-add multiplier controller that time-
//            shares one external 32-bit adder (one iteration per clock).
// Revision : 1.0 - initial release
// ============================================================================
module mul32_seq_ctrl #(
    parameter int STEPS = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_multiplicand,
    input  logic [31:0] i_multiplier,
    input  logic        i_result_ack,
    output logic [31:0] o_adder_a,
    output logic [31:0] o_adder_b,
    output logic        o_adder_cin,
    input  logic [31:0] i_adder_sum,
    input  logic        i_adder_cout,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [63:0]        r_p;
    logic [31:0]        r_m;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack takes priority in DONE simply because start is only examined in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start)              w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == c_last_step) w_state_nxt = S_DONE;
            S_DONE:  if (i_result_ack)         w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    // Upper half accumulates; the 33-bit adder result shifts right one bit into P.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m   <= i_multiplicand;
                        r_p   <= {32'h0, i_multiplier};
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_p   <= {i_adder_cout, i_adder_sum, r_p[31:1]};
                    r_cnt <= r_cnt + c_cnt_one;
                end
                default: ;
            endcase
        end
    end

    assign w_busy      = (r_state == S_BUSY);
    assign o_busy      = w_busy;
    assign o_done      = (r_state == S_DONE);
    assign o_product   = r_p;

    // A zero multiplier bit still goes through the adder as "+0".
    assign o_adder_a   = w_busy ? r_p[63:32] : 32'h0;
    assign o_adder_b   = (w_busy && r_p[0]) ? r_m : 32'h0;
    assign o_adder_cin = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mul32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul32_seq_ctrl
// Purpose  : Self-checking bench for mul32_seq_ctrl with an external adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        ack = 1'b0;
    logic [31:0] adder_a, adder_b, adder_sum;
    logic        adder_cin, adder_cout;
    logic        busy, done;
    logic [63:0] product;

    int n_vec = 0;
    int n_err = 0;
    bit saw_cout = 0;

    always #5 clk = ~clk;

    // External ripple adder stand-in
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {32'h0, adder_cin};

    mul32_seq_ctrl #(.STEPS(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_multiplicand (mcand),
        .i_multiplier   (mplier),
        .i_result_ack   (ack),
        .o_adder_a      (adder_a),
        .o_adder_b      (adder_b),
        .o_adder_cin    (adder_cin),
        .i_adder_sum    (adder_sum),
        .i_adder_cout   (adder_cout),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Protocol-level reference: phase, step count and the arithmetic product.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
    mphase_t     m_ph = M_IDLE;
    int          m_steps = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = M_IDLE;
            m_steps = 0;
            m_prod = '0;
        end else begin
            case (m_ph)
                M_IDLE: if (start) begin
                    m_ph = M_BUSY;
                    m_steps = 0;
                    m_pend = 64'(mcand) * 64'(mplier);
                end
                M_BUSY: begin
                    m_steps++;
                    if (m_steps == 32) begin
                        m_ph = M_DONE;
                        m_prod = m_pend;
                    end
                end
                M_DONE: if (ack) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {63'h0, busy}, {63'h0, m_ph == M_BUSY});
            check("done", {63'h0, done}, {63'h0, m_ph == M_DONE});
            check("adder_cin", {63'h0, adder_cin}, 64'h0);
            if (m_ph != M_BUSY) begin
                check("adder_a_idle", {32'h0, adder_a}, 64'h0);
                check("adder_b_idle", {32'h0, adder_b}, 64'h0);
                check("product", product, m_prod);
            end
            if (busy && adder_cout) saw_cout = 1;
        end
    end

    // Runs one multiplication from IDLE; leaves the DUT in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name,
                          input bit scramble, input bit poke);
        int lat;
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (scramble) begin mcand = $urandom; mplier = $urandom; end
            if (poke) start = (lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_product"}, product, exp);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_product", product, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset in the middle of 7x9
        @(negedge clk);
        mcand = 32'd7; mplier = 32'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'h0, busy}, 64'h0);
        check("arst_done", {63'h0, done}, 64'h0);
        check("arst_product", product, 64'h0);
        check("arst_adder_a", {32'h0, adder_a}, 64'h0);
        check("arst_adder_b", {32'h0, adder_b}, 64'h0);
        check("arst_adder_cin", {63'h0, adder_cin}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        run_op(32'd7, 32'd9, 64'd63, "7x9", 0, 0);
        do_ack();

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5", 0, 0);
        // start during DONE is ignored
        @(negedge clk);
        mcand = 32'd100; mplier = 32'd100; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_in_done_done", {63'h0, done}, 64'h1);
        check("start_in_done_product", product, 64'hF);
        repeat (20) @(posedge clk);
        #1 check("hold_product", product, 64'hF);
        // start and ack together: ack wins
        @(negedge clk);
        start = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b0;
        check("start_ack_busy", {63'h0, busy}, 64'h0);
        check("start_ack_done", {63'h0, done}, 64'h0);
        check("start_ack_product", product, 64'hF);

        run_op(32'h0, 32'hFFFF_FFFF, 64'h0, "0xF", 0, 0);
        do_ack();
        run_op(32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF, "Fx1", 0, 1);
        do_ack();
        saw_cout = 0;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "FxF", 0, 0);
        check("max_saw_cout", {63'h0, saw_cout}, 64'h1);
        do_ack();
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, "isolation", 1, 0);
        do_ack();

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 64'(ra) * 64'(rb), $sformatf("rand%0d", i), 0, 0);
            do_ack();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
